lwe_op_scheduler: RTL and testbench

- Queues LWE instructions (encrypt/decrypt/add/multiply) written over the Wishbone opcode register.
- Issues them one at a time to the compute core, waits for completion, and enforces a watchdog timeout.
- Sits between the Wishbone slave decode (opcode address 0x30000000) and the core's start/done interface.
- Lets firmware post several ops back-to-back without polling between them.

---
 rtl/lwe_op_scheduler_pkg.sv | 35 +++
 rtl/lwe_op_scheduler_fifo.sv | 77 +++++++
 rtl/lwe_op_scheduler.sv | 157 +++++++++++++++
 tb/tb_lwe_op_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lwe_op_scheduler_pkg.sv
// Shared constants for the LWE op scheduler: opcodes, instruction-word field
// offsets and the issue FSM encoding.
package lwe_sched_pkg;

  localparam logic [1:0] OP_ENC = 2'd0;
  localparam logic [1:0] OP_DEC = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;

  // The opcode sits below OPC_LSB; the address fields start there.
  localparam int OPC_LSB  = 2;
  localparam int SRC1_LSB = 2;
  localparam int SRC2_LSB = 11;
  localparam int DEST_LSB = 20;
  localparam int GO_BIT   = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_e;

  function automatic logic op_reads_src2(input logic [1:0] op);
    logic r;
    case (op)
      OP_ENC:  r = 1'b0;
      OP_DEC:  r = 1'b0;
      OP_ADD:  r = 1'b1;
      OP_MUL:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lwe_op_scheduler_fifo.sv
// Instruction queue for the scheduler: synchronous FIFO with flush, a
// registered full flag and an occupancy count.
module sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 29
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic [PW:0]      count_d;
  logic             full_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push_i && !full_q && !flush_i;
  assign do_pop_s  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + {{PW{1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{PW{1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  // Storage carries no reset; only entries below the count are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push_s) wr_ptr_q <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        if (do_pop_s)  rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      count_q <= count_d;
      full_q  <= (count_d == (PW+1)'(DEPTH));
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/lwe_op_scheduler.sv
// Queues LWE instructions from the opcode register and issues them one at a
// time to the compute core, aborting any op the core fails to finish in time.
module lwe_op_scheduler
  import lwe_sched_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int QUEUE_DEPTH = 4,
  parameter int TIMEOUT     = 64,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         cmd_valid,
  input  logic [31:0]                  cmd_data,
  output logic                         cmd_ready,
  input  logic                         flush,
  input  logic                         clear_err,
  output logic                         core_start,
  output logic [1:0]                   core_opcode,
  output logic [ADDR_WIDTH-1:0]        core_src1,
  output logic [ADDR_WIDTH-1:0]        core_src2,
  output logic [ADDR_WIDTH-1:0]        core_dest,
  input  logic                         core_done,
  output logic                         core_abort,
  output logic                         busy,
  output logic [$clog2(QUEUE_DEPTH):0] q_count,
  output logic [CNT_WIDTH-1:0]         done_count,
  output logic                         err_timeout,
  output logic                         err_overflow
);

  localparam int EW = 2 + 3*ADDR_WIDTH;
  localparam int TW = $clog2(TIMEOUT);

  sched_state_e          state_q;
  logic [TW-1:0]         timer_q;
  logic                  start_q;
  logic                  abort_q;
  logic [1:0]            opcode_q;
  logic [ADDR_WIDTH-1:0] src1_q;
  logic [ADDR_WIDTH-1:0] src2_q;
  logic [ADDR_WIDTH-1:0] dest_q;
  logic [CNT_WIDTH-1:0]  done_cnt_q;
  logic                  err_to_q;
  logic                  err_ov_q;

  logic                  push_req_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [EW-1:0]         fifo_din_s;
  logic [EW-1:0]         fifo_head_s;
  logic [$clog2(QUEUE_DEPTH):0] fifo_count_s;
  logic                  timeout_ev_s;
  logic                  unused_s;

  assign push_req_s = cmd_valid && cmd_data[GO_BIT];
  assign fifo_din_s = {cmd_data[OPC_LSB-1:0],
                       cmd_data[SRC1_LSB +: ADDR_WIDTH],
                       cmd_data[SRC2_LSB +: ADDR_WIDTH],
                       cmd_data[DEST_LSB +: ADDR_WIDTH]};
  assign unused_s   = ^cmd_data[GO_BIT-1:DEST_LSB+ADDR_WIDTH];

  sched_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push_req_s),
    .pop_i   (state_q == ST_ISSUE),
    .flush_i (flush),
    .din_i   (fifo_din_s),
    .dout_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Completion in the expiry cycle takes priority over the watchdog.
  assign timeout_ev_s = (state_q == ST_WAIT) && !core_done &&
                        (timer_q == TW'(TIMEOUT-1));

  // Issue FSM; an op is not launched in a cycle that is flushing the queue.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      opcode_q   <= 2'd0;
      src1_q     <= '0;
      src2_q     <= '0;
      dest_q     <= '0;
      done_cnt_q <= '0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s && !err_to_q && !flush) begin
            state_q  <= ST_ISSUE;
            start_q  <= 1'b1;
            opcode_q <= fifo_head_s[EW-1 -: 2];
            src1_q   <= fifo_head_s[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
            src2_q   <= fifo_head_s[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
            dest_q   <= fifo_head_s[ADDR_WIDTH-1:0];
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            done_cnt_q <= done_cnt_q + CNT_WIDTH'(1);
            state_q    <= ST_IDLE;
          end else if (timeout_ev_s) begin
            abort_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new error event outranks clear_err.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      if (timeout_ev_s)   err_to_q <= 1'b1;
      else if (clear_err) err_to_q <= 1'b0;
      if (push_req_s && fifo_full_s) err_ov_q <= 1'b1;
      else if (clear_err)            err_ov_q <= 1'b0;
    end
  end

  assign cmd_ready    = !fifo_full_s;
  assign core_start   = start_q;
  assign core_abort   = abort_q;
  assign core_opcode  = opcode_q;
  assign core_src1    = src1_q;
  assign core_src2    = src2_q;
  assign core_dest    = dest_q;
  assign busy         = (state_q != ST_IDLE) || (fifo_count_s != '0);
  assign q_count      = fifo_count_s;
  assign done_count   = done_cnt_q;
  assign err_timeout  = err_to_q;
  assign err_overflow = err_ov_q;

endmodule

// File: tb/tb_lwe_op_scheduler.sv
// Directed bench for lwe_op_scheduler with a queue-based reference model
// compared against the DUT on every falling edge.
module tb_lwe_op_scheduler;

  localparam int AW = 9;
  localparam int QD = 4;
  localparam int TO = 64;
  localparam int CW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data = 32'd0;
  logic        flush = 1'b0;
  logic        clear_err = 1'b0;
  logic        core_done = 1'b0;
  logic        cmd_ready, core_start, core_abort, busy, err_timeout, err_overflow;
  logic [1:0]  core_opcode;
  logic [AW-1:0] core_src1, core_src2, core_dest;
  logic [2:0]  q_count;
  logic [CW-1:0] done_count;

  lwe_op_scheduler #(.ADDR_WIDTH(AW), .QUEUE_DEPTH(QD), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .flush(flush), .clear_err(clear_err),
    .core_start(core_start), .core_opcode(core_opcode), .core_src1(core_src1),
    .core_src2(core_src2), .core_dest(core_dest), .core_done(core_done),
    .core_abort(core_abort), .busy(busy), .q_count(q_count), .done_count(done_count),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int s1, input int s2, input int d);
    logic [31:0] w;
    w = {1'b1, 2'b00, d[8:0], s2[8:0], s1[8:0], op[1:0]};
    return w;
  endfunction

  // Reference model: a queue of pending ops, the op currently owned by the
  // core, and how long the core has held it.
  logic [28:0] mq[$];
  int          m_phase = 0;   // 0 idle, 1 issuing, 2 core working
  int          m_timer = 0;
  bit          m_start = 1'b0;
  bit          m_abort = 1'b0;
  bit          m_err_to = 1'b0;
  bit          m_err_ov = 1'b0;
  int          m_done = 0;
  logic [28:0] m_fields = 29'd0;

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_timer = 0; m_start = 0; m_abort = 0;
    m_err_to = 0; m_err_ov = 0; m_done = 0; m_fields = 29'd0;
  endtask

  task automatic model_step();
    bit go_push;
    bit to_ev;
    int sz;
    go_push = cmd_valid && cmd_data[31];
    sz = mq.size();
    to_ev = 1'b0;
    m_start = 1'b0;
    m_abort = 1'b0;
    if (m_phase == 0) begin
      if (sz > 0 && !m_err_to && !flush) begin
        m_phase = 1; m_start = 1'b1; m_fields = mq[0];
      end
    end else if (m_phase == 1) begin
      if (mq.size() > 0) void'(mq.pop_front());
      m_timer = 0; m_phase = 2;
    end else begin
      if (core_done) begin
        m_done = (m_done + 1) % 256; m_phase = 0;
      end else if (m_timer == TO - 1) begin
        to_ev = 1'b1; m_abort = 1'b1; m_phase = 0;
      end else begin
        m_timer++;
      end
    end
    if (flush) mq.delete();
    else if (go_push && sz < QD)
      mq.push_back({cmd_data[1:0], cmd_data[10:2], cmd_data[19:11], cmd_data[28:20]});
    if (to_ev) m_err_to = 1'b1;
    else if (clear_err) m_err_to = 1'b0;
    if (go_push && sz == QD) m_err_ov = 1'b1;
    else if (clear_err) m_err_ov = 1'b0;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("m_cmd_ready", cmd_ready, mq.size() < QD);
      chk("m_q_count", q_count, mq.size());
      chk("m_busy", busy, (m_phase != 0) || (mq.size() != 0));
      chk("m_core_start", core_start, m_start);
      chk("m_core_abort", core_abort, m_abort);
      chk("m_fields", {core_opcode, core_src1, core_src2, core_dest}, m_fields);
      chk("m_done_count", done_count, m_done);
      chk("m_err_timeout", err_timeout, m_err_to);
      chk("m_err_overflow", err_overflow, m_err_ov);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    cmd_valid = 1'b1; cmd_data = w;
    tick();
    cmd_valid = 1'b0; cmd_data = 32'd0;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!core_start && n < 20) begin
      tick();
      n++;
    end
    chk("start_seen", core_start, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin : stim
    int k;
    int s;
    int exp_op[3] = '{2, 1, 3};
    #2;
    rst = 1'b1;
    chk_on = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("mk_pin", mk(2, 0, 100, 50), 32'h83232002);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_q_count", q_count, 3'd0);
    chk("rst_done_count", done_count, 8'd0);

    // Single op: issue two edges after acceptance
    push(32'h83232002);
    chk("t1_no_start_yet", core_start, 1'b0);
    tick();
    chk("t1_start", core_start, 1'b1);
    chk("t1_opcode", core_opcode, 2'd2);
    chk("t1_src1", core_src1, 9'd0);
    chk("t1_src2", core_src2, 9'd100);
    chk("t1_dest", core_dest, 9'd50);
    repeat (3) tick();
    pulse_done();
    chk("t1_done_count", done_count, 8'd1);
    chk("t1_busy", busy, 1'b0);

    // Three ops back to back, issued strictly in order
    do_reset();
    push(mk(2, 1, 2, 3));
    push(mk(1, 5, 100, 30));
    chk("t2_issue0", core_start, 1'b1);
    chk("t2_op0", core_opcode, 2'd2);
    push(mk(3, 7, 8, 40));
    chk("t2_q_count", q_count, 3'd2);
    repeat (3) tick();
    pulse_done();
    for (int i = 1; i < 3; i++) begin
      wait_start();
      chk("t2_op_order", core_opcode, exp_op[i]);
      repeat (3) tick();
      pulse_done();
    end
    chk("t2_done_count", done_count, 8'd3);

    // Overflow while the core is stalled
    do_reset();
    push(mk(0, 1, 1, 1));
    wait_start();
    tick();
    for (int i = 0; i < 4; i++) push(mk(i, i, i + 1, i + 2));
    chk("t3_ready_low", cmd_ready, 1'b0);
    chk("t3_q_full", q_count, 3'd4);
    push(mk(3, 9, 9, 9));
    chk("t3_err_ov", err_overflow, 1'b1);
    chk("t3_q_hold", q_count, 3'd4);
    tick();
    pulse_done();
    wait_start();
    chk("t3_q_at_issue", q_count, 3'd4);
    tick();
    chk("t3_q_after_pop", q_count, 3'd3);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t3_err_ov_clr", err_overflow, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        wait_start();
        tick();
      end
      pulse_done();
    end
    chk("t3_done_count", done_count, 8'd5);
    chk("t3_busy", busy, 1'b0);

    // Watchdog: abort exactly TIMEOUT cycles after WAIT entry
    do_reset();
    push(mk(2, 3, 4, 5));
    push(mk(3, 6, 7, 8));
    wait_start();
    tick();
    k = 0;
    while (!core_abort && k < 100) begin
      tick();
      k++;
    end
    chk("t4_abort_cycles", k, 64);
    chk("t4_err_to", err_timeout, 1'b1);
    tick();
    chk("t4_abort_pulse", core_abort, 1'b0);
    repeat (10) tick();
    chk("t4_held_q", q_count, 3'd1);
    chk("t4_held_start", core_start, 1'b0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t4_err_clr", err_timeout, 1'b0);
    tick();
    chk("t4_resume_start", core_start, 1'b1);
    chk("t4_resume_op", core_opcode, 2'd3);
    tick();
    pulse_done();
    chk("t4_done_count", done_count, 8'd1);

    // Flush during WAIT leaves the in-flight op alone
    do_reset();
    push(mk(0, 1, 2, 3));
    push(mk(1, 4, 5, 6));
    push(mk(2, 7, 8, 9));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_q_flushed", q_count, 3'd0);
    chk("t5_busy_wait", busy, 1'b1);
    tick();
    pulse_done();
    chk("t5_done_count", done_count, 8'd1);
    s = 0;
    repeat (8) begin
      tick();
      if (core_start) s++;
    end
    chk("t5_no_more_starts", s, 0);
    chk("t5_idle", busy, 1'b0);

    // go=0 words are ignored; reset during WAIT gives no abort
    do_reset();
    push(mk(1, 2, 3, 4) & 32'h7fffffff);
    tick();
    chk("t6_nogo_q", q_count, 3'd0);
    chk("t6_nogo_err", err_overflow, 1'b0);
    chk("t6_nogo_busy", busy, 1'b0);
    push(mk(2, 11, 12, 13));
    wait_start();
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_abort", core_abort, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_ready", cmd_ready, 1'b1);
    chk("t6_rst_dest", core_dest, 9'd0);
    chk("t6_rst_err", err_timeout, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t6_after_rst_busy", busy, 1'b0);
    chk("t6_after_rst_abort", core_abort, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
